idu_decode_stage: RTL

- Instruction-decode stage directly downstream of the fetch stage. It consumes the fetched instruction and its PC through a valid/ready handshake.
- Holds them in a single-entry pipeline register and decodes RV32I fields: register indices, immediate, ALU op and control class.
- Presents the decoded bundle to the execute stage with the same valid/ready protocol.
- Supports a flush from branch/jump resolution, which discards the held instruction.

---
 rtl/idu_decode_stage.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/idu_decode_stage.sv
// RV32I instruction decode stage: single-entry pipeline register
// between fetch and execute, with combinational field decode.
module idu_decode_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prev_valid,
  output logic              ready_o,
  input  logic [DATA_W-1:0] inst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              next_ready,
  output logic              valid_o,
  input  logic              flush,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [4:0]        rd_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [3:0]        alu_op_o,
  output logic              wen_o,
  output logic              src2_imm_o,
  output logic              src1_pc_o,
  output logic              is_load_o,
  output logic              is_store_o,
  output logic              is_branch_o,
  output logic              is_jal_o,
  output logic              is_jalr_o,
  output logic              is_ebreak_o,
  output logic              is_ecall_o,
  output logic              illegal_o,
  output logic [2:0]        funct3_o
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  logic              valid_q;
  logic [DATA_W-1:0] inst_q;
  logic [ADDR_W-1:0] pc_q;
  logic              accept;
  logic              send;

  assign ready_o = (!valid_q || next_ready) && !flush;
  assign accept  = prev_valid && ready_o;
  assign send    = valid_q && next_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      pc_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      inst_q  <= inst;
      pc_q    <= pc;
    end else if (send) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;

  assign op       = inst_q[6:0];
  assign f3       = inst_q[14:12];
  assign f7       = inst_q[31:25];
  assign funct3_o = f3;
  assign rd_o     = inst_q[11:7];
  assign rs2_o    = inst_q[24:20];

  logic op_lui, op_auipc, op_jal, op_jalr, op_br;
  logic op_ld, op_st, op_imm, op_reg, op_fence, op_sys;

  assign op_lui   = (op == 7'h37);
  assign op_auipc = (op == 7'h17);
  assign op_jal   = (op == 7'h6f);
  assign op_jalr  = (op == 7'h67);
  assign op_br    = (op == 7'h63);
  assign op_ld    = (op == 7'h03);
  assign op_st    = (op == 7'h23);
  assign op_imm   = (op == 7'h13);
  assign op_reg   = (op == 7'h33);
  assign op_fence = (op == 7'h0f);
  assign op_sys   = (op == 7'h73);

  assign rs1_o = op_lui ? 5'd0 : inst_q[19:15];

  logic [DATA_W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{inst_q[31]}}, inst_q[31:20]};
  assign imm_s = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
  assign imm_b = {{19{inst_q[31]}}, inst_q[31], inst_q[7],
                  inst_q[30:25], inst_q[11:8], 1'b0};
  assign imm_u = {inst_q[31:12], 12'b0};
  assign imm_j = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12],
                  inst_q[20], inst_q[30:21], 1'b0};

  // funct7[5] picks SUB only for register ops, SRA for both forms
  logic [3:0] alu_f3;

  always_comb begin
    alu_f3 = ALU_ADD;
    unique case (f3)
      3'd0: alu_f3 = (op_reg && f7[5]) ? ALU_SUB : ALU_ADD;
      3'd1: alu_f3 = ALU_SLL;
      3'd2: alu_f3 = ALU_SLT;
      3'd3: alu_f3 = ALU_SLTU;
      3'd4: alu_f3 = ALU_XOR;
      3'd5: alu_f3 = f7[5] ? ALU_SRA : ALU_SRL;
      3'd6: alu_f3 = ALU_OR;
      3'd7: alu_f3 = ALU_AND;
      default: alu_f3 = ALU_ADD;
    endcase
  end

  logic known, writes, ld, st, br, jal, jalr;

  always_comb begin
    imm_o      = '0;
    alu_op_o   = ALU_ADD;
    src2_imm_o = 1'b0;
    src1_pc_o  = 1'b0;
    known      = 1'b1;
    writes     = 1'b0;
    ld         = 1'b0;
    st         = 1'b0;
    br         = 1'b0;
    jal        = 1'b0;
    jalr       = 1'b0;
    unique case (1'b1)
      op_lui: begin
        imm_o = imm_u; src2_imm_o = 1'b1; writes = 1'b1;
      end
      op_auipc: begin
        imm_o = imm_u; src2_imm_o = 1'b1; src1_pc_o = 1'b1;
        writes = 1'b1;
      end
      op_jal: begin
        imm_o = imm_j; src2_imm_o = 1'b1; src1_pc_o = 1'b1;
        writes = 1'b1; jal = 1'b1;
      end
      op_jalr: begin
        imm_o = imm_i; src2_imm_o = 1'b1; writes = 1'b1;
        jalr = 1'b1;
      end
      op_br: begin
        imm_o = imm_b; alu_op_o = ALU_SUB; br = 1'b1;
      end
      op_ld: begin
        imm_o = imm_i; src2_imm_o = 1'b1; writes = 1'b1;
        ld = 1'b1;
      end
      op_st: begin
        imm_o = imm_s; src2_imm_o = 1'b1; st = 1'b1;
      end
      op_imm: begin
        imm_o = imm_i; src2_imm_o = 1'b1; writes = 1'b1;
        alu_op_o = alu_f3;
      end
      op_reg: begin
        writes = 1'b1; alu_op_o = alu_f3;
      end
      op_fence: imm_o = imm_i;
      op_sys:   imm_o = imm_i;
      default:  known = 1'b0;
    endcase
  end

  logic ecall, ebreak, bad_f7, illegal;

  assign ecall  = op_sys && (inst_q == 32'h0000_0073);
  assign ebreak = op_sys && (inst_q == 32'h0010_0073);
  assign bad_f7 = op_reg && !((f7 == 7'h00) ||
                  ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
  assign illegal = !known || bad_f7 || (op_sys && !ecall && !ebreak);

  assign illegal_o   = illegal;
  assign wen_o       = writes && (rd_o != 5'd0) && !illegal;
  assign is_load_o   = ld && !illegal;
  assign is_store_o  = st && !illegal;
  assign is_branch_o = br && !illegal;
  assign is_jal_o    = jal && !illegal;
  assign is_jalr_o   = jalr && !illegal;
  assign is_ebreak_o = ebreak;
  assign is_ecall_o  = ecall;

endmodule
